// File: rtl/inst_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package inst_prefetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] START_ADDR_DEFAULT = 32'h0000_0000;

    // One queued fetch result: the address it came from and the word read.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Force a byte address onto a 32-bit word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_prefetch_if.sv
// ROM request/response and decode-side handshake of the prefetch unit.
interface inst_prefetch_if;
    import inst_prefetch_pkg::*;

    logic            imem_en;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;
    logic            out_ready;

    // Prefetch unit side
    modport master (
        output imem_en, imem_addr, out_valid, out_pc, out_inst,
        input  imem_rdata, redirect, redirect_pc, out_ready
    );

    // ROM / branch unit / decode side
    modport slave (
        input  imem_en, imem_addr, out_valid, out_pc, out_inst,
        output imem_rdata, redirect, redirect_pc, out_ready
    );

endinterface

// File: rtl/inst_prefetch_fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, inst} pairs with single-cycle flush.
module fetch_fifo
    import inst_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wr_data,
    output fetch_entry_t             rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_s;
    logic          pop_s;

    // Qualify requests against occupancy so pointers can never run past each other
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (flush) begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end else begin
            push_s = push && (count_r != DEPTH_C);
            pop_s  = pop && (count_r != {CW{1'b0}});
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage, cleared on reset so the head reads as zero afterwards
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{pc: 32'h0000_0000, inst: 32'h0000_0000};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetch: issues sequential ROM reads, queues the results for
// decode, and restarts at a new address on a taken branch/jump.
module inst_prefetch
    import inst_prefetch_pkg::*;
#(
    parameter int              DEPTH      = 4,
    parameter logic [XLEN-1:0] START_ADDR = START_ADDR_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    inst_prefetch_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] inflight_pc_r;
    logic            inflight_r;
    logic [CW-1:0]   count_s;
    logic [CW-1:0]   occupancy_s;
    logic            issue_s;
    logic            push_s;
    logic            pop_s;
    logic            out_valid_s;
    fetch_entry_t    push_entry_s;
    fetch_entry_t    head_entry_s;

    // Issue only while queued plus outstanding entries leave room; a redirect
    // cancels both the issue and the response landing this cycle
    always_comb begin
        occupancy_s  = count_s + CW'(inflight_r);
        out_valid_s  = (count_s != {CW{1'b0}});
        pop_s        = out_valid_s & bus.out_ready;
        push_entry_s = '{pc: inflight_pc_r, inst: bus.imem_rdata};
        issue_s      = 1'b0;
        push_s       = 1'b0;
        if (reset || bus.redirect) begin
            issue_s = 1'b0;
            push_s  = 1'b0;
        end else begin
            issue_s = (occupancy_s < DEPTH_C);
            push_s  = inflight_r;
        end
    end

    // Next fetch address and the single outstanding ROM request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_r    <= word_align(START_ADDR);
            inflight_r    <= 1'b0;
            inflight_pc_r <= {XLEN{1'b0}};
        end else if (bus.redirect) begin
            fetch_pc_r <= word_align(bus.redirect_pc);
            inflight_r <= 1'b0;
        end else if (issue_s) begin
            inflight_r    <= 1'b1;
            inflight_pc_r <= fetch_pc_r;
            fetch_pc_r    <= fetch_pc_r + 32'd4;
        end else begin
            inflight_r <= 1'b0;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_s),
        .pop     (pop_s),
        .flush   (bus.redirect),
        .wr_data (push_entry_s),
        .rd_data (head_entry_s),
        .count   (count_s)
    );

    assign bus.imem_en   = issue_s;
    assign bus.imem_addr = fetch_pc_r;
    assign bus.out_valid = out_valid_s;
    assign bus.out_pc    = head_entry_s.pc;
    assign bus.out_inst  = head_entry_s.inst;

endmodule

// File: doc/inst_prefetch.md
# inst_prefetch

Instruction prefetch unit between the synchronous-read instruction ROM and the CPU decode stage. Keeps a small queue of fetched {pc, inst} pairs so decode sees one instruction per cycle despite the ROM's one-cycle read latency. Redirects from the branch/jump resolution logic (jbr_taken/jbr_target) flush the queue and restart fetch at the new target.

## Interface
- DEPTH, 4, queue entries (power of two, ≥2)
- START_ADDR, 32'd0, fetch address after reset
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- imem_en  out  1  ROM read strobe; data returned next cycle
- imem_addr  out  32  ROM byte address, bits [1:0] always 00
- imem_rdata  in  32  ROM data for the address strobed the previous cycle
- redirect  in  1  taken branch/jump this cycle
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 00)
- out_valid  out  1  queue head holds a valid instruction
- out_pc  out  32  head PC
- out_inst  out  32  head instruction
- out_ready  in  1  decode accepts head this cycle

## Operation
- State: fetch_pc (next address to request), inflight flag + inflight_pc (request issued last cycle), queue of DEPTH {pc, inst}, count.
- Issue: imem_en = !reset_state & !redirect & (count + inflight < DEPTH), using registered count/inflight. imem_addr = fetch_pc. On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32).
- Response: when inflight=1 and no redirect this cycle, push {inflight_pc, imem_rdata}. Issue gating guarantees space; push never occurs on a full queue.
- Pop: out_valid & out_ready removes head. Push and pop in the same cycle: count unchanged.
- out_valid = (count != 0); out_pc/out_inst driven from head register, no comb path from imem_rdata.
- Redirect (priority over everything except reset): a pop in the same cycle completes normally (the consumed head is the branch itself); all other entries flushed, count<=0; inflight response discarded; inflight<=0; fetch_pc<={redirect_pc[31:2],2'b00}; no issue that cycle.
- Reset: fetch_pc=START_ADDR, count=0, inflight=0, queue storage=0. Outputs during reset: imem_en=0, imem_addr=START_ADDR, out_valid=0, out_pc=0, out_inst=0. Reset mid-operation discards the inflight response.

## Timing
- First imem_en: first rising edge after reset deasserts (cycle 0); out_valid earliest cycle 2.
- Fetch latency: issue at T, rdata sampled at end of T+1, out_valid at T+2.
- Redirect at N: imem_en at N+1 with addr=redirect_pc; first new out_valid at N+3, out_pc=redirect_pc.
- Steady state with out_ready=1: one instruction per cycle, PCs consecutive +4.
- out_ready=0 held: queue fills to DEPTH, imem_en drops once count+inflight=DEPTH; resumes the cycle after the first pop.
- Address wrap: fetch_pc 32'hFFFF_FFFC → 32'h0000_0000.

## Structure
- Shared package: START_ADDR default, instruction/address width constants (32), entry typedef {pc[31:0], inst[31:0]}.
- One sub-module: fetch_fifo — synchronous FIFO, DEPTH entries, push/pop/flush, count, async active-high reset. inst_prefetch holds fetch_pc, inflight tracking, issue and redirect logic.

## Test plan
- Reset release, out_ready=1, ROM returns addr+32'h100 as data → imem_addr 0,4,8,…; out_valid from cycle 2; out_pc 0,4,8 with out_inst 0x100,0x104,0x108, one per cycle.
- out_ready=0 for 10 cycles → exactly 4 imem_en pulses, count=4, out_pc stays 0; set out_ready=1 → pops 0,4,8,12 consecutively, fetch resumes at 16 with no gap or duplicate.
- Redirect at cycle N to 32'h40 with queue partly full and a request inflight → imem_addr=0x40 at N+1, next out_pc=0x40 at N+3, no stale PCs ever presented.
- Redirect with redirect_pc=32'h43 simultaneous with pop of head → head accepted once; imem_addr=0x40.
- START_ADDR=32'hFFFF_FFF8 → out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert reset mid-stream with inflight=1 → outputs to reset values immediately; after release fetch restarts at START_ADDR, discarded response never enqueued.
